// File: rtl/word_shift_fifo_pkg.sv
// Shared types and constants for the word-serial shift buffer.
// Optional recirculation is enabled with the WORD_SHIFT_ROTATE_EN macro.
package word_shift_pkg;

    // Bits needed to hold an occupancy count from 0 to n inclusive.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Index of a storage slot (slot 0 is the head).
    typedef int unsigned slot_idx_t;

    // Value a slot takes at reset or when vacated; truncated to the word width.
    localparam logic [255:0] RESET_WORD = '0;

    // Next-value selection for a single slot register.
    typedef enum logic [2:0] {
        SLOT_HOLD,
        SLOT_SHIFT,
        SLOT_WRITE,
        SLOT_LOAD,
        SLOT_CLEAR
    } slot_op_t;

endpackage

// File: rtl/word_shift_fifo_if.sv
// Stream/load bundle between the shift buffer and its producer/consumer.
// The rotate signal exists only when WORD_SHIFT_ROTATE_EN is defined.
interface word_shift_fifo_if
    import word_shift_pkg::*;
#(
    parameter int NWORDS = 4,
    parameter int WBITS  = 32
);
    localparam int CW = count_width(NWORDS);

    logic                    load;
    logic [NWORDS*WBITS-1:0] load_data;
    logic                    in_valid;
    logic [WBITS-1:0]        in_data;
    logic                    in_ready;
    logic                    out_valid;
    logic [WBITS-1:0]        out_data;
    logic                    out_ready;
`ifdef WORD_SHIFT_ROTATE_EN
    logic                    rotate;
`endif
    logic [CW-1:0]           count;
    logic                    full;
    logic                    empty;

    modport master (
`ifdef WORD_SHIFT_ROTATE_EN
        output rotate,
`endif
        output load, load_data, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count, full, empty
    );

    modport slave (
`ifdef WORD_SHIFT_ROTATE_EN
        input  rotate,
`endif
        input  load, load_data, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count, full, empty
    );

endinterface

// File: rtl/word_shift_fifo_slot.sv
// One storage slot of the shift buffer with its next-value mux.
module word_shift_slot
    import word_shift_pkg::*;
#(
    parameter int WBITS = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  slot_op_t         op,
    input  logic [WBITS-1:0] shift_in,
    input  logic [WBITS-1:0] write_data,
    input  logic [WBITS-1:0] load_word,
    output logic [WBITS-1:0] q
);

    // Slot register: hold, take the neighbour's word, a new word, a load word, or clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= WBITS'(RESET_WORD);
        end else begin
            case (op)
                SLOT_SHIFT: q <= shift_in;
                SLOT_WRITE: q <= write_data;
                SLOT_LOAD:  q <= load_word;
                SLOT_CLEAR: q <= WBITS'(RESET_WORD);
                default:    q <= q;
            endcase
        end
    end

endmodule

// File: rtl/word_shift_fifo.sv
// Word-serial shift buffer: parallel load or push, head-first pop, optional
// recirculation (WORD_SHIFT_ROTATE_EN). Occupied slots stay packed at slot 0.
module word_shift_fifo
    import word_shift_pkg::*;
#(
    parameter int NWORDS = 4,
    parameter int WBITS  = 32
) (
    input  logic              clock,
    input  logic              reset,
    word_shift_fifo_if.slave  bus
);

    localparam int            CW         = count_width(NWORDS);
    localparam logic [CW-1:0] FULL_COUNT = CW'(NWORDS);

    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic [CW-1:0]    tail_idx;
    logic [WBITS-1:0] slot_q [NWORDS];
    logic [WBITS-1:0] write_data;
    logic             rotate_mode;
    logic             full;
    logic             empty;
    logic             pop;
    logic             push;

`ifdef WORD_SHIFT_ROTATE_EN
    assign rotate_mode = bus.rotate;
`else
    assign rotate_mode = 1'b0;
`endif

    assign full  = (count_reg == FULL_COUNT);
    assign empty = (count_reg == '0);

    assign bus.out_valid = !empty && !bus.load;
    assign bus.out_data  = slot_q[0];
    assign bus.in_ready  = !bus.load && !rotate_mode && (!full || bus.out_ready);
    assign bus.count     = count_reg;
    assign bus.full      = full;
    assign bus.empty     = empty;

    assign pop  = bus.out_valid && bus.out_ready;
    assign push = bus.in_valid && bus.in_ready;

    // In rotate mode the popped head word is what lands at the tail.
    assign write_data = rotate_mode ? slot_q[0] : bus.in_data;
    // Only meaningful when a pop happens, which implies count_reg > 0.
    assign tail_idx   = count_reg - CW'(1);

    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_slot
            slot_op_t         op;
            logic [WBITS-1:0] neighbour;

            if (gi == NWORDS - 1) begin : g_last
                assign neighbour = WBITS'(RESET_WORD);
            end else begin : g_inner
                assign neighbour = slot_q[gi+1];
            end

            // Select this slot's next value from load/pop/push and its position vs. the tail.
            always_comb begin
                op = SLOT_HOLD;
                if (bus.load) begin
                    op = SLOT_LOAD;
                end else if (pop) begin
                    if (CW'(gi) == tail_idx) begin
                        op = (push || rotate_mode) ? SLOT_WRITE : SLOT_CLEAR;
                    end else if (CW'(gi) < tail_idx) begin
                        op = SLOT_SHIFT;
                    end
                end else if (push && (CW'(gi) == count_reg)) begin
                    op = SLOT_WRITE;
                end
            end

            word_shift_slot #(.WBITS(WBITS)) u_slot (
                .clock      (clock),
                .reset      (reset),
                .op         (op),
                .shift_in   (neighbour),
                .write_data (write_data),
                .load_word  (bus.load_data[NWORDS*WBITS-1-gi*WBITS -: WBITS]),
                .q          (slot_q[gi])
            );
        end
    endgenerate

    // Occupancy: load fills, lone pop drains one, lone push adds one; swap and rotate hold.
    always_comb begin
        count_next = count_reg;
        if (bus.load) begin
            count_next = FULL_COUNT;
        end else if (pop && !push && !rotate_mode) begin
            count_next = count_reg - CW'(1);
        end else if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end
    end

    // Occupancy register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: doc/word_shift_fifo.md
# word_shift_fifo

Parametrised word-serial shift buffer for the pseudo-inverse datapath: holds up to NWORDS words of WBITS each, accepts a full matrix row by parallel load or word-by-word push, and emits words head-first over a valid/ready stream. It adds occupancy tracking, backpressure and an optional rotate (recirculate) mode. It sits between the row/column memories and the MAC array, replacing fixed four-word shifting.

## Interface
- NWORDS, 4, number of word slots (≥2)
- WBITS, 32, word width in bits
- CW, $clog2(NWORDS+1), count width (derived, not overridable)

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- load  in  1  parallel load of all slots
- load_data  in  NWORDS*WBITS  word k at bits [NWORDS*WBITS-1-k*WBITS -: WBITS]; word 0 (MSBs) emitted first
- in_valid  in  1  push request
- in_data  in  WBITS  push word
- in_ready  out  1  push accepted when in_valid & in_ready
- out_valid  out  1  head word valid
- out_data  out  WBITS  head word (slot 0)
- out_ready  in  1  pop when out_valid & out_ready
- rotate  in  1  recirculate mode (present only with WORD_SHIFT_ROTATE_EN)
- count  out  CW  occupied slots, 0..NWORDS
- full  out  1  count == NWORDS
- empty  out  1  count == 0

## Operation
- Storage: slots 0..NWORDS-1, slot 0 = head; occupied slots always contiguous from 0; vacated slots written 0.
- out_valid = !empty & !load; out_data = slot 0 (combinational from register).
- in_ready = !load & !rotate & (!full | out_ready).
- Priority per edge: load > pop/push.
- Load: all slots ← load_data, count ← NWORDS; no push or pop occurs that cycle.
- Pop only: slots shift one toward head, last occupied slot cleared, count−1.
- Push only: in_data written to slot count, count+1.
- Push+pop same cycle: shift toward head, in_data written to slot count−1, count unchanged (legal at full).
- Rotate (rotate=1, pop): shift toward head, popped word written to slot count−1, count unchanged; pushes blocked.
- Pop when empty impossible (out_valid=0); push when in_ready=0 ignored.
- Arithmetic: count never wraps; no overflow/underflow paths exist by construction.

## Timing
- Reset (async assert, any state): all slots 0, count 0, empty 1, full 0, out_valid 0, out_data 0, in_ready 1 (if load=0, rotate=0).
- Load at edge N → out_valid=1, out_data=word 0, count=NWORDS from N+1.
- Push into empty at edge N → out_valid=1 from N+1 (latency 1).
- Pop at edge N → next word on out_data from N+1; back-to-back pops every cycle sustain 1 word/clock.
- in_ready depends combinationally on out_ready; out_ready must not depend on in_ready.
- rotate sampled per cycle; changes take effect on the same edge.

## Configuration
- WORD_SHIFT_ROTATE_EN defined: rotate port present, recirculation as above.
- Undefined: rotate port absent, treated as 0; in_ready = !load & (!full | out_ready).

## Structure
- Package word_shift_pkg: count-width function, slot-index type, reset word constant (all zeros).
- Sub-module word_shift_slot: one slot register with next-value mux (hold / shift-in from neighbour / in_data / load word / clear); top instantiates NWORDS via generate plus count logic.

## Test plan
- Reset mid-stream (count=3) → next cycle count 0, empty 1, out_data 0, out_valid 0.
- Load {A,B,C,D}=0x11111111,0x22222222,0x33333333,0x44444444, out_ready=1 four cycles → out_data A,B,C,D, then empty=1, count 0.
- Push 4 words with out_ready=0 → full=1, in_ready=0, fifth push ignored, count stays 4.
- At full, in_valid=1 & out_ready=1 with 0x55555555 → pops A, count stays 4, sequence B,C,D,0x55555555.
- Rotate (macro defined): load {A,B,C,D}, rotate=1, 6 pops → A,B,C,D,A,B, count 4, in_ready=0 throughout.
- Load asserted with in_valid=1 & out_ready=1 → load wins, no pop/push, count 4, out_data A next cycle.
